digit_serial_rom_adder: RTL and testbench



---
 rtl/digit_serial_rom_adder_pkg.sv | 13 +
 rtl/rom_digit_add.sv | 21 ++
 rtl/digit_serial_rom_adder.sv | 112 +++++++++++
 tb/tb_digit_serial_rom_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_rom_adder_pkg.sv
// digit_serial_rom_adder_pkg: FSM state type and ROM entry generator for the digit-serial adder
package digit_serial_rom_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Entry {c,x,y} of the digit ROM holds x + y + c as {carry, digit sum}
  function automatic int rom_entry(input int digit, input int idx);
    int mask;
    mask = (1 << digit) - 1;
    return ((idx >> (2 * digit)) & 1) + ((idx >> digit) & mask) + (idx & mask);
  endfunction

endpackage

// File: rtl/rom_digit_add.sv
// rom_digit_add: combinational ROM mapping {carry, x digit, y digit} to {carry out, sum digit}
module rom_digit_add
  import digit_serial_rom_adder_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [2*DIGIT:0] addr_i,
  output logic [DIGIT:0]   data_o
);

  localparam int DEPTH = 1 << (2 * DIGIT + 1);

  logic [DIGIT:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = (DIGIT + 1)'(rom_entry(DIGIT, i));
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/digit_serial_rom_adder.sv
// digit_serial_rom_adder: WIDTH-bit adder processing DIGIT bits per cycle via a ROM, start/busy/done handshake
// Optional: DIGIT_SERIAL_ROM_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module digit_serial_rom_adder
  import digit_serial_rom_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, acc_d, sum_q;
  logic             carry_q, c_next, cout_q, busy_q, done_q;
  logic [DIGIT-1:0] s_dig;
  logic             last, accept;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
  logic             a_msb_q, b_msb_q, ovf_q;
`endif

  rom_digit_add #(.DIGIT(DIGIT)) u_rom (
    .addr_i({carry_q, a_sh_q[DIGIT-1:0], b_sh_q[DIGIT-1:0]}),
    .data_o({c_next, s_dig})
  );

  // New digit enters at the top so the first (least significant) digit ends at the bottom
  always_comb begin
    acc_d  = WIDTH'({s_dig, acc_q} >> DIGIT);
    last   = idx_q == IW'(NDIG - 1);
    accept = start && (state_q != RUN);
  end

  // Handshake FSM with datapath shift registers and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        a_sh_q  <= a;
        b_sh_q  <= b;
        carry_q <= cin;
        idx_q   <= '0;
        acc_q   <= '0;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
        a_sh_q  <= a_sh_q >> DIGIT;
        b_sh_q  <= b_sh_q >> DIGIT;
        carry_q <= c_next;
        acc_q   <= acc_d;
        idx_q   <= idx_q + 1'b1;
        if (last) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          sum_q   <= acc_d;
          cout_q  <= c_next;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
          ovf_q   <= (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
`endif
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_rom_adder.sv
// tb_digit_serial_rom_adder: directed self-checking bench for 8-bit and 4-bit digit-serial ROM adders
module tb_digit_serial_rom_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif
  int n_cmp = 0;
  int n_fail = 0;
  logic got;

  always #5 clk = ~clk;

  digit_serial_rom_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  digit_serial_rom_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit operation and wait (bounded) for done; leaves time just after the done edge
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (done8) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_fail++; $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
    end
    n_cmp++;
    if ({busy4, done4, sum4, cout4} !== 7'd0) begin
      n_fail++; $display("FAIL reset4 got busy=%b done=%b sum=%h cout=%b want all 0", busy4, done4, sum4, cout4);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      n_cmp++;
      if (busy8 !== (k < 4)) begin
        n_fail++; $display("FAIL basic_busy after E%0d got %b want %b", k, busy8, k < 4);
      end
      n_cmp++;
      if (done8 !== (k == 4)) begin
        n_fail++; $display("FAIL basic_done after E%0d got %b want %b", k, done8, k == 4);
      end
      if (k == 4) begin
        n_cmp++;
        if ({cout8, sum8} !== 9'h096) begin
          n_fail++; $display("FAIL basic_sum got cout=%b sum=%h want cout=0 sum=96", cout8, sum8);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    go8(8'hFF, 8'h01, 1'b0);
    n_cmp++;
    if (!got || {cout8, sum8} !== 9'h100) begin
      n_fail++; $display("FAIL b2b_first done=%b got cout=%b sum=%h want cout=1 sum=00", got, cout8, sum8);
    end
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) begin
        n_cmp++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || {cout8, sum8} !== 9'h100) begin
          n_fail++; $display("FAIL b2b_hold step %0d got done=%b busy=%b cout=%b sum=%h want 0 1 1 00", k, done8, busy8, cout8, sum8);
        end
      end else begin
        n_cmp++;
        if (done8 !== 1'b1 || {cout8, sum8} !== 9'h1FF) begin
          n_fail++; $display("FAIL b2b_second got done=%b cout=%b sum=%h want 1 1 ff", done8, cout8, sum8);
        end
      end
      if (k < 5) tick();
    end
    tick();
    tick();
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_cmp++;
      if (done8 !== (k % 5 == 0)) begin
        n_fail++; $display("FAIL held_start tick %0d got done=%b want %b", k, done8, k % 5 == 0);
      end
    end
    n_cmp++;
    if ({cout8, sum8} !== 9'h003) begin
      n_fail++; $display("FAIL held_start_sum got cout=%b sum=%h want 0 03", cout8, sum8);
    end
    start8 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    if (done8) dones++;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done8) dones++;
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL ignore_start_dones got %0d want 1", dones);
    end
    n_cmp++;
    if ({cout8, sum8} !== 9'h046) begin
      n_fail++; $display("FAIL ignore_start_sum got cout=%b sum=%h want 0 46", cout8, sum8);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_fail++; $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done8 || busy8) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL async_reset_quiet got %0d active cycles want 0", dones);
    end
    go8(8'h21, 8'h43, 1'b1);
    n_cmp++;
    if (!got || {cout8, sum8} !== 9'h065) begin
      n_fail++; $display("FAIL after_reset done=%b got cout=%b sum=%h want 0 65", got, cout8, sum8);
    end
    tick();
  endtask

  task automatic test_exhaustive4();
    logic [4:0] want;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          got = 1'b0;
          for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (done4) got = 1'b1;
          end
          want = 5'(x + y + c);
          n_cmp++;
          if (!got || {cout4, sum4} !== want) begin
            n_fail++; $display("FAIL exh4 %0d+%0d+%0d done=%b got %h want %h", x, y, c, got, {cout4, sum4}, want);
          end
          if (x == 3 && y == 3 && c == 1) begin
            n_cmp++;
            if (sum4 !== 4'd7 || cout4 !== 1'b0) begin
              n_fail++; $display("FAIL exh4_331 got cout=%b sum=%0d want 0 7", cout4, sum4);
            end
          end
        end
    tick();
  endtask

`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
  task automatic test_ovf();
    go8(8'h7F, 8'h01, 1'b0);
    n_cmp++;
    if (!got || ovf8 !== 1'b1 || sum8 !== 8'h80) begin
      n_fail++; $display("FAIL ovf_7f got ovf=%b sum=%h want 1 80", ovf8, sum8);
    end
    tick();
    go8(8'h80, 8'h80, 1'b0);
    n_cmp++;
    if (!got || ovf8 !== 1'b1 || cout8 !== 1'b1 || sum8 !== 8'h00) begin
      n_fail++; $display("FAIL ovf_80 got ovf=%b cout=%b sum=%h want 1 1 00", ovf8, cout8, sum8);
    end
    tick();
    go8(8'h10, 8'h20, 1'b0);
    n_cmp++;
    if (!got || ovf8 !== 1'b0 || sum8 !== 8'h30) begin
      n_fail++; $display("FAIL ovf_10 got ovf=%b sum=%h want 0 30", ovf8, sum8);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_exhaustive4();
`ifdef DIGIT_SERIAL_ROM_ADDER_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
